step_sequencer: RTL and testbench
=================================

# step_sequencer

Timing-step generator for the CPU control unit. Produces the binary step index `step` that drives the one-hot step decoder (`decoder`, BITS-wide) directly downstream, so exactly one control-step line is active per cycle. A small run/halt state machine handles instruction wrap, early instruction termination, stall and halt, with optional direct step loading for microcode jumps.

## Interface
- `BITS`, 2, width of `step`; must equal the downstream decoder's `BITS`.
- `LAST`, 2**BITS-1, final step index of an instruction; legal range 0 .. 2**BITS-1.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE/HALT and enter RUN.
- `halt`  in  1  enter HALT, freezing `step`.
- `stall`  in  1  hold `step` in RUN for this cycle.
- `step_clr`  in  1  end the current instruction early; next step is 0.
- `load_en`  in  1  load `load_val` into `step` (only with `STEP_SEQ_LOAD_EN`).
- `load_val`  in  BITS  step value to load (only with `STEP_SEQ_LOAD_EN`).
- `step`  out  BITS  current step index, registered.
- `running`  out  1  high while in RUN, registered.
- `halted`  out  1  high while in HALT, registered.
- `instr_done`  out  1  one-cycle pulse marking the first cycle of a new instruction, registered.

## Operation
- States: IDLE (reset state), RUN, HALT.
- Reset (`rst_n`=0, asynchronous): state=IDLE, `step`=0, `running`=0, `halted`=0, `instr_done`=0. Reset mid-instruction discards the step immediately.
- IDLE: `step` held at 0. `halt` → HALT. Otherwise `start` → RUN. `halt` wins when asserted together with `start`.
- RUN, per-cycle priority (highest first):
  - `halt` → HALT; `step` frozen.
  - `stall` → `step` held. `step_clr`, wrap and load are ignored that cycle.
  - `load_en` (macro only) → `step`=`load_val`. No `instr_done`.
  - `step_clr`, or `step`==`LAST` → `step`=0; `instr_done`=1 next cycle.
  - Otherwise `step`=`step`+1.
- HALT: `step` frozen. `start` → RUN, resuming from the frozen step. `halt` and `start` asserted together keep the block in HALT.
- `LAST`=0: every unstalled RUN cycle wraps, so `instr_done` stays high continuously.
- Increment never exceeds `LAST`. `load_val` > `LAST` is accepted; the block then counts up and wraps at 2**BITS-1 → 0 without an `instr_done` pulse. Only `step`==`LAST` or `step_clr` generates `instr_done`.

## Timing
- All outputs change only on the rising edge of `clk`, except during asynchronous reset. There are no combinational input→output paths.
- `start` sampled at edge N: `running`=1 after edge N. The first RUN cycle shows `step`=0, or the frozen step when resuming from HALT. The first increment happens at edge N+1.
- `instr_done` is high for exactly the cycle in which `step` shows 0 after a wrap or `step_clr`.
- `halt` sampled at edge N: `halted`=1 and `running`=0 after edge N.
- Downstream decoder output is valid in the same cycle as `step`.

## Configuration
- `STEP_SEQ_LOAD_EN` defined: `load_en`/`load_val` ports exist and take part in the RUN priority as above.
- Not defined: the ports are absent and the load branch is removed. Every other behaviour is identical.

## Structure
- Package `step_seq_pkg`: state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_HALT`=2'd2.
- One sub-module, `step_counter`: BITS-wide register with async reset, hold, sync clear, load and increment. The FSM in `step_sequencer` drives its control inputs.

## Test plan
- Reset, then `start` pulse, BITS=2, LAST=3 → `step` 0,1,2,3,0,1…; `instr_done` high exactly on each `step`=0 after the first.
- LAST=2, `step_clr` asserted at `step`=1 → next `step`=0 with `instr_done`=1. Without `step_clr`, 0,1,2,0.
- `stall` high for 3 cycles at `step`=2 → `step` stays 2 for 3 cycles, then advances to 3. `step_clr` during the stall has no effect.
- `halt` at `step`=1 → `halted`=1, `step` stays 1. A later `start` → `running`=1, resumes 1, then 2. `halt` with `start` in IDLE → HALT, `step`=0.
- `rst_n` dropped asynchronously mid-cycle at `step`=3 → immediately `step`=0, `running`=0, `instr_done`=0, state IDLE.
- With `STEP_SEQ_LOAD_EN`, BITS=4, LAST=9: `load_en` with `load_val`=7 at `step`=2 → 7,8,9,0, `instr_done` on the 0. A load during `stall` is ignored.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared definitions for the step sequencer: run/halt state encodings.
package step_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // True for the three encodings the FSM can legally occupy.
  function automatic logic state_is_legal(input state_t s);
    logic ok;
    case (s)
      ST_IDLE: ok = 1'b1;
      ST_RUN:  ok = 1'b1;
      ST_HALT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/step_counter.sv
// BITS-wide step register: async reset, sync clear, load, increment, hold.
// Control priority is clear > load > increment; with none asserted it holds.
// The increment wraps naturally at 2**BITS-1 -> 0.
module step_counter #(
  parameter int BITS = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [BITS-1:0] i_load_val,
  input  logic            i_inc,
  output logic [BITS-1:0] o_q
);

  logic [BITS-1:0] r_q;

  // Step register update with clear/load/increment priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {BITS{1'b0}};
    end else if (i_clr) begin
      r_q <= {BITS{1'b0}};
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_inc) begin
      r_q <= r_q + BITS'(1'b1);
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/step_sequencer.sv
// Timing-step generator for the CPU control unit.
// Optional feature macro: STEP_SEQ_LOAD_EN adds i_load_en/i_load_val for
// microcode jumps; without it the load branch and ports are absent.
// All outputs come straight from flops; no input reaches an output
// combinationally.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int BITS = 2,
  parameter int LAST = (1 << BITS) - 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_stall,
  input  logic            i_step_clr,
`ifdef STEP_SEQ_LOAD_EN
  input  logic            i_load_en,
  input  logic [BITS-1:0] i_load_val,
`endif
  output logic [BITS-1:0] o_step,
  output logic            o_running,
  output logic            o_halted,
  output logic            o_instr_done
);

  localparam logic [BITS-1:0] LAST_STEP = BITS'(LAST);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_cnt_clr;
  logic            w_cnt_load;
  logic            w_cnt_inc;
  logic            w_done_nxt;
  logic            w_load_req;
  logic [BITS-1:0] w_load_val;
  logic [BITS-1:0] w_step;
  logic            r_running;
  logic            r_halted;
  logic            r_instr_done;

`ifdef STEP_SEQ_LOAD_EN
  assign w_load_req = i_load_en;
  assign w_load_val = i_load_val;
`else
  assign w_load_req = 1'b0;
  assign w_load_val = {BITS{1'b0}};
`endif

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
      r_instr_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_running    <= (w_state_nxt == ST_RUN);
      r_halted     <= (w_state_nxt == ST_HALT);
      r_instr_done <= w_done_nxt;
    end
  end

  // Next-state and counter control; halt beats stall beats load beats wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Step is pinned to 0 while idle.
        w_cnt_clr = 1'b1;
        if (i_halt) begin
          w_state_nxt = ST_HALT;
        end else if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          w_state_nxt = ST_HALT;
        end else if (i_stall) begin
          w_state_nxt = ST_RUN;
        end else if (w_load_req) begin
          // A jump is not an instruction boundary: no done pulse.
          w_cnt_load = 1'b1;
        end else if (i_step_clr || (w_step == LAST_STEP)) begin
          w_cnt_clr  = 1'b1;
          w_done_nxt = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_HALT: begin
        // Resume from the frozen step; a simultaneous halt keeps us here.
        if (i_start && !i_halt) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        // Recover from an illegal encoding by returning to a clean idle.
        w_state_nxt = ST_IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
    if (!state_is_legal(r_state)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  step_counter #(
    .BITS(BITS)
  ) u_step_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (w_load_val),
    .i_inc      (w_cnt_inc),
    .o_q        (w_step)
  );

  assign o_step       = w_step;
  assign o_running    = r_running;
  assign o_halted     = r_halted;
  assign o_instr_done = r_instr_done;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer. Four instances with different
// BITS/LAST share one stimulus stream and are checked against a per-instance
// behavioural model of the run/halt/step rules.
module tb_step_sequencer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       stall = 1'b0;
  logic       step_clr = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;

  int vectors = 0;
  int fails = 0;

  logic [1:0] a_step, b_step, z_step;
  logic [3:0] c_step;
  logic [N-1:0] obs_run, obs_halt, obs_done;
  logic [3:0] obs_step [N];

  // Model state: 0 idle, 1 run, 2 halt.
  int         m_state [N];
  int         m_step  [N];
  logic [3:0] exp_step [N];
  logic       exp_run  [N];
  logic       exp_halt [N];
  logic       exp_done [N];

  always #5 clk = ~clk;

  step_sequencer #(.BITS(2), .LAST(3)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt),
    .i_stall(stall), .i_step_clr(step_clr),
`ifdef STEP_SEQ_LOAD_EN
    .i_load_en(load_en), .i_load_val(load_val[1:0]),
`endif
    .o_step(a_step), .o_running(obs_run[0]), .o_halted(obs_halt[0]),
    .o_instr_done(obs_done[0]));

  step_sequencer #(.BITS(2), .LAST(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt),
    .i_stall(stall), .i_step_clr(step_clr),
`ifdef STEP_SEQ_LOAD_EN
    .i_load_en(load_en), .i_load_val(load_val[1:0]),
`endif
    .o_step(b_step), .o_running(obs_run[1]), .o_halted(obs_halt[1]),
    .o_instr_done(obs_done[1]));

  step_sequencer #(.BITS(4), .LAST(9)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt),
    .i_stall(stall), .i_step_clr(step_clr),
`ifdef STEP_SEQ_LOAD_EN
    .i_load_en(load_en), .i_load_val(load_val),
`endif
    .o_step(c_step), .o_running(obs_run[2]), .o_halted(obs_halt[2]),
    .o_instr_done(obs_done[2]));

  step_sequencer #(.BITS(2), .LAST(0)) u_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_halt(halt),
    .i_stall(stall), .i_step_clr(step_clr),
`ifdef STEP_SEQ_LOAD_EN
    .i_load_en(load_en), .i_load_val(load_val[1:0]),
`endif
    .o_step(z_step), .o_running(obs_run[3]), .o_halted(obs_halt[3]),
    .o_instr_done(obs_done[3]));

  assign obs_step[0] = {2'b00, a_step};
  assign obs_step[1] = {2'b00, b_step};
  assign obs_step[2] = c_step;
  assign obs_step[3] = {2'b00, z_step};

  function automatic int inst_bits(input int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int inst_last(input int i);
    case (i)
      0:       return 3;
      1:       return 2;
      2:       return 9;
      default: return 0;
    endcase
  endfunction

  function automatic void model_publish();
    for (int i = 0; i < N; i++) begin
      exp_step[i] = 4'(m_step[i]);
      exp_run[i]  = (m_state[i] == 1);
      exp_halt[i] = (m_state[i] == 2);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i]  = 0;
      m_step[i]   = 0;
      exp_done[i] = 1'b0;
    end
    model_publish();
  endfunction

  // One clock edge of the specified behaviour, using the inputs now applied.
  function automatic void model_clock();
    logic ld;
`ifdef STEP_SEQ_LOAD_EN
    ld = load_en;
`else
    ld = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      int modv;
      modv = 1 << inst_bits(i);
      exp_done[i] = 1'b0;
      if (m_state[i] == 0) begin
        m_step[i] = 0;
        if (halt) m_state[i] = 2;
        else if (start) m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        if (halt) begin
          m_state[i] = 2;
        end else if (stall) begin
          m_step[i] = m_step[i];
        end else if (ld) begin
          m_step[i] = int'(load_val) % modv;
        end else if (step_clr || m_step[i] == inst_last(i)) begin
          m_step[i]   = 0;
          exp_done[i] = 1'b1;
        end else begin
          m_step[i] = (m_step[i] + 1) % modv;
        end
      end else begin
        if (start && !halt) m_state[i] = 1;
      end
    end
    model_publish();
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; halt = 1'b0; stall = 1'b0; step_clr = 1'b0;
    load_en = 1'b0; load_val = 4'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({obs_step[i], obs_run[i], obs_halt[i], obs_done[i]} !== 7'd0) begin
        fails++;
        $display("FAIL reset inst%0d: got step=%0d run=%b halt=%b done=%b, want all zero",
                 i, obs_step[i], obs_run[i], obs_halt[i], obs_done[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    apply_reset();
    start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      start = 1'b0;
      vectors++;
      if (obs_step[0] !== 4'(k % 4) || obs_done[0] !== (k > 0 && k % 4 == 0)) begin
        fails++;
        $display("FAIL wrap_seq k=%0d: got step=%0d done=%b, want step=%0d done=%b",
                 k, obs_step[0], obs_done[0], k % 4, (k > 0 && k % 4 == 0));
      end
      for (int i = 0; i < N; i++) begin
        vectors++;
        if ({obs_step[i], obs_run[i], obs_halt[i], obs_done[i]} !==
            {exp_step[i], exp_run[i], exp_halt[i], exp_done[i]}) begin
          fails++;
          $display("FAIL wrap inst%0d k=%0d: got step=%0d run=%b halt=%b done=%b, want step=%0d run=%b halt=%b done=%b",
                   i, k, obs_step[i], obs_run[i], obs_halt[i], obs_done[i],
                   exp_step[i], exp_run[i], exp_halt[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_step_clr();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    step_clr = 1'b1;
    tick();
    step_clr = 1'b0;
    vectors++;
    if (obs_step[1] !== 4'd0 || obs_done[1] !== 1'b1) begin
      fails++;
      $display("FAIL step_clr: got step=%0d done=%b, want step=0 done=1", obs_step[1], obs_done[1]);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        vectors++;
        if ({obs_step[i], obs_run[i], obs_halt[i], obs_done[i]} !==
            {exp_step[i], exp_run[i], exp_halt[i], exp_done[i]}) begin
          fails++;
          $display("FAIL clr_run inst%0d k=%0d: got step=%0d done=%b, want step=%0d done=%b",
                   i, k, obs_step[i], obs_done[i], exp_step[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stall = 1'b1;
    step_clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        stall = 1'b0;
        step_clr = 1'b0;
      end
      tick();
      vectors++;
      if (obs_step[0] !== ((k == 3) ? 4'd3 : 4'd2) || obs_done[0] !== 1'b0) begin
        fails++;
        $display("FAIL stall k=%0d: got step=%0d done=%b, want step=%0d done=0",
                 k, obs_step[0], obs_done[0], (k == 3) ? 3 : 2);
      end
    end
  endtask

  task automatic test_halt();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    tick();
    vectors++;
    if ({obs_step[0], obs_run[0], obs_halt[0]} !== {4'd1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL halt_freeze: got step=%0d run=%b halt=%b, want step=1 run=0 halt=1",
               obs_step[0], obs_run[0], obs_halt[0]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({obs_step[0], obs_run[0], obs_halt[0]} !== {4'd1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL halt_resume: got step=%0d run=%b halt=%b, want step=1 run=1 halt=0",
               obs_step[0], obs_run[0], obs_halt[0]);
    end
    tick();
    vectors++;
    if (obs_step[0] !== 4'd2) begin
      fails++;
      $display("FAIL halt_advance: got step=%0d, want 2", obs_step[0]);
    end
    apply_reset();
    halt = 1'b1;
    start = 1'b1;
    tick();
    tick();
    vectors++;
    if ({obs_step[0], obs_run[0], obs_halt[0]} !== {4'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL halt_start_idle: got step=%0d run=%b halt=%b, want step=0 run=0 halt=1",
               obs_step[0], obs_run[0], obs_halt[0]);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (obs_step[0] !== 4'd3) begin
      fails++;
      $display("FAIL areset_pre: got step=%0d, want 3", obs_step[0]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({obs_step[i], obs_run[i], obs_halt[i], obs_done[i]} !== 7'd0) begin
        fails++;
        $display("FAIL areset inst%0d: got step=%0d run=%b halt=%b done=%b, want all zero",
                 i, obs_step[i], obs_run[i], obs_halt[i], obs_done[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef STEP_SEQ_LOAD_EN
  task automatic test_load();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    load_en = 1'b1;
    load_val = 4'd7;
    for (int k = 0; k < 4; k++) begin
      tick();
      load_en = 1'b0;
      vectors++;
      if (obs_step[2] !== ((k == 3) ? 4'd0 : 4'(7 + k)) || obs_done[2] !== (k == 3)) begin
        fails++;
        $display("FAIL load k=%0d: got step=%0d done=%b, want step=%0d done=%b",
                 k, obs_step[2], obs_done[2], (k == 3) ? 0 : 7 + k, (k == 3));
      end
    end
    stall = 1'b1;
    load_en = 1'b1;
    load_val = 4'd5;
    tick();
    clear_inputs();
    vectors++;
    if (obs_step[2] !== 4'd0) begin
      fails++;
      $display("FAIL load_stall: got step=%0d, want 0", obs_step[2]);
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      start    = ($urandom_range(3) == 0);
      halt     = ($urandom_range(15) == 0);
      stall    = ($urandom_range(4) == 0);
      step_clr = ($urandom_range(7) == 0);
      load_en  = ($urandom_range(7) == 0);
      load_val = 4'($urandom_range(15));
      tick();
      for (int i = 0; i < N; i++) begin
        vectors++;
        if ({obs_step[i], obs_run[i], obs_halt[i], obs_done[i]} !==
            {exp_step[i], exp_run[i], exp_halt[i], exp_done[i]}) begin
          fails++;
          $display("FAIL random inst%0d k=%0d: got step=%0d run=%b halt=%b done=%b, want step=%0d run=%b halt=%b done=%b",
                   i, k, obs_step[i], obs_run[i], obs_halt[i], obs_done[i],
                   exp_step[i], exp_run[i], exp_halt[i], exp_done[i]);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_step_clr();
    test_stall();
    test_halt();
    test_async_reset();
`ifdef STEP_SEQ_LOAD_EN
    test_load();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
